frame_buffer_ctrl: RTL and testbench

Bus-mapped frame buffer controller sitting directly upstream of the VGA signal generator. Holds the 320×240, 1-bit-per-pixel image in a 2^17×1 RAM. The microprocessor writes pixels and colour configuration over the 8-bit memory-mapped bus. The VGA generator reads pixels through a second, look-ahead read port. An optional fill engine clears or sets the whole buffer autonomously.

---
 rtl/fb_pkg.sv | 19 +
 rtl/fb_ram_dp.sv | 23 ++
 rtl/frame_buffer_ctrl.sv | 146 ++++++++++++++
 tb/tb_frame_buffer_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame buffer controller and its RAM.
package fb_pkg;
  localparam int ADDR_W    = 17;
  localparam int X_MAX_DEF = 320;
  localparam int Y_MAX_DEF = 240;

  localparam logic [2:0] OFF_XLO = 3'd0;
  localparam logic [2:0] OFF_XHI = 3'd1;
  localparam logic [2:0] OFF_Y   = 3'd2;
  localparam logic [2:0] OFF_PIX = 3'd3;
  localparam logic [2:0] OFF_FG  = 3'd4;
  localparam logic [2:0] OFF_BG  = 3'd5;
  localparam logic [2:0] OFF_CTL = 3'd6;

  localparam logic [15:0]       COLOUR_RST = 16'hFF00;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  typedef enum logic {IDLE, FILL} fill_state_t;
endpackage

// File: rtl/fb_ram_dp.sv
// 128K x 1 block RAM: one write port, one enabled registered read-first read port.
module fb_ram_dp
  import fb_pkg::*;
(
  input  logic              CLK,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);
  logic mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge CLK)
    if (we) mem[waddr] <= wdata;

  // Output register reset maps onto the block RAM output latch reset.
  always_ff @(posedge CLK)
    if (rst)     rdata <= 1'b0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/frame_buffer_ctrl.sv
// Bus-mapped 320x240x1 frame buffer with VGA look-ahead read port.
// Optional fill engine and status register built when FB_FILL_EN is defined.
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter int         X_MAX     = X_MAX_DEF,
  parameter int         Y_MAX     = Y_MAX_DEF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BUS_ADDR,
  inout  wire  [7:0]  BUS_DATA,
  input  logic        BUS_WE,
  input  logic        VGA_RD_EN,
  input  logic [16:0] VGA_ADDR,
  output logic        VGA_DATA,
  output logic [15:0] CONFIG_COLOURS
);
  localparam logic [8:0] X_LIM = 9'(X_MAX);
  localparam logic [7:0] Y_LIM = 8'(Y_MAX);

  logic [7:0] off_full;
  logic [2:0] off;
  logic       hit, wr_hit;
  logic [8:0] x;
  logic [7:0] y, fg, bg;
  logic [7:0] rd_mux, rd_q;
  logic       rd_oe;
  logic       busy, pix_we;
  logic              ram_we, ram_wdata;
  logic [ADDR_W-1:0] ram_waddr;

  assign off_full = BUS_ADDR - BASE_ADDR;
  assign off      = off_full[2:0];
  assign hit      = (BUS_ADDR >= BASE_ADDR) && (off_full <= 8'd6);
  assign wr_hit   = hit && BUS_WE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      x  <= '0;
      y  <= '0;
      fg <= COLOUR_RST[15:8];
      bg <= COLOUR_RST[7:0];
    end else if (wr_hit) begin
      case (off)
        OFF_XLO: x[7:0] <= BUS_DATA;
        OFF_XHI: x[8]   <= BUS_DATA[0];
        OFF_Y:   y      <= BUS_DATA;
        OFF_FG:  fg     <= BUS_DATA;
        OFF_BG:  bg     <= BUS_DATA;
        default: ;
      endcase
    end
  end

  assign CONFIG_COLOURS = {fg, bg};

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_XLO: rd_mux = x[7:0];
      OFF_XHI: rd_mux = {7'b0, x[8]};
      OFF_Y:   rd_mux = y;
      OFF_FG:  rd_mux = fg;
      OFF_BG:  rd_mux = bg;
      OFF_CTL: rd_mux = {7'b0, busy};
      default: rd_mux = '0;
    endcase
  end

  // Bus is driven only in the cycle after a decoded read.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_oe <= 1'b0;
      rd_q  <= '0;
    end else begin
      rd_oe <= hit && !BUS_WE;
      rd_q  <= rd_mux;
    end
  end

  assign BUS_DATA = rd_oe ? rd_q : 8'hzz;

  assign pix_we = wr_hit && (off == OFF_PIX) && (x < X_LIM) && (y < Y_LIM) && !busy;

`ifdef FB_FILL_EN
  fill_state_t       state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic              fill_val, fill_we, start;

  assign start = wr_hit && (off == OFF_CTL) && BUS_DATA[0];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_val <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == IDLE && start) fill_val <= BUS_DATA[1];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fill_we   = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nxt = FILL;
        cnt_nxt   = '0;
      end
      FILL: begin
        fill_we = 1'b1;
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == FILL);
  // Reset gates the write so an aborted fill stops on the reset edge.
  assign ram_we    = (fill_we || pix_we) && !RESET;
  assign ram_waddr = fill_we ? cnt : {y, x};
  assign ram_wdata = fill_we ? fill_val : BUS_DATA[0];
`else
  assign busy      = 1'b0;
  assign ram_we    = pix_we && !RESET;
  assign ram_waddr = {y, x};
  assign ram_wdata = BUS_DATA[0];
`endif

  fb_ram_dp u_ram (
    .CLK   (CLK),
    .rst   (RESET),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (VGA_RD_EN),
    .raddr (VGA_ADDR),
    .rdata (VGA_DATA)
  );
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// Self-checking bench for frame_buffer_ctrl; fill tests run when FB_FILL_EN is defined.
module tb_frame_buffer_ctrl;
  localparam logic [7:0] BASE = 8'hB0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR;
  wire  [7:0]  BUS_DATA;
  logic        BUS_WE;
  logic        VGA_RD_EN;
  logic [16:0] VGA_ADDR;
  logic        VGA_DATA;
  logic [15:0] CONFIG_COLOURS;
  logic [7:0]  drv;
  logic        drv_en;

  assign BUS_DATA = drv_en ? drv : 8'hzz;

  frame_buffer_ctrl dut (
    .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
    .BUS_WE(BUS_WE), .VGA_RD_EN(VGA_RD_EN), .VGA_ADDR(VGA_ADDR),
    .VGA_DATA(VGA_DATA), .CONFIG_COLOURS(CONFIG_COLOURS)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference picture: value and whether the bench knows it.
  bit mem_m   [0:131071];
  bit known_m [0:131071];
  logic [7:0] fg_m = 8'hFF, bg_m = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bw(input logic [2:0] off, input logic [7:0] d);
    BUS_ADDR = BASE + {5'b0, off};
    drv = d; drv_en = 1'b1; BUS_WE = 1'b1;
    @(posedge CLK); #1;
    BUS_WE = 1'b0; drv_en = 1'b0; BUS_ADDR = 8'h00;
  endtask

  task automatic br(input logic [2:0] off, output logic [7:0] d);
    BUS_ADDR = BASE + {5'b0, off}; BUS_WE = 1'b0;
    @(posedge CLK); #1;
    BUS_ADDR = 8'h00;
    d = BUS_DATA;
    @(posedge CLK); #1;
  endtask

  task automatic vr(input logic [16:0] a, output logic v);
    VGA_ADDR = a; VGA_RD_EN = 1'b1;
    @(posedge CLK); #1;
    VGA_RD_EN = 1'b0;
    v = VGA_DATA;
  endtask

  function automatic int pa(input int x, input int y);
    return y * 512 + x;
  endfunction

  task automatic pix(input int x, input int y, input bit v);
    logic [8:0] xv;
    xv = 9'(x);
    bw(3'd0, xv[7:0]);
    bw(3'd1, {7'b0, xv[8]});
    bw(3'd2, 8'(y));
    bw(3'd3, {7'b0, v});
    if (x < 320 && y < 240) begin
      mem_m[pa(x, y)]   = v;
      known_m[pa(x, y)] = 1'b1;
    end
  endtask

  typedef struct {
    logic [2:0] off;
    logic       wr;
    logic [7:0] d;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [7:0] rd;
    logic       v, p, p2;
    int         busy_cnt;

    tbl[0] = '{3'd0, 1'b1, 8'h5A, 8'h5A};
    tbl[1] = '{3'd1, 1'b1, 8'hFF, 8'h01};
    tbl[2] = '{3'd2, 1'b1, 8'h77, 8'h77};
    tbl[3] = '{3'd3, 1'b0, 8'h00, 8'h00};
    tbl[4] = '{3'd4, 1'b1, 8'h1C, 8'h1C};
    tbl[5] = '{3'd5, 1'b1, 8'hE0, 8'hE0};
    tbl[6] = '{3'd6, 1'b0, 8'h00, 8'h00};
    tbl[7] = '{3'd1, 1'b1, 8'h00, 8'h00};
    tbl[8] = '{3'd0, 1'b0, 8'h00, 8'h5A};
    tbl[9] = '{3'd2, 1'b1, 8'hEF, 8'hEF};

    RESET = 1'b1; BUS_ADDR = 8'h00; BUS_WE = 1'b0; drv = 8'h00; drv_en = 1'b0;
    VGA_RD_EN = 1'b0; VGA_ADDR = '0;
    repeat (3) @(posedge CLK);
    #1 RESET = 1'b0;

    chk("rst_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    chk("rst_vga", 32'(VGA_DATA), 32'h0);
    br(3'd0, rd); chk("rst_xlo", 32'(rd), 32'h00);
    br(3'd1, rd); chk("rst_xhi", 32'(rd), 32'h00);
    br(3'd2, rd); chk("rst_y", 32'(rd), 32'h00);
    br(3'd6, rd); chk("rst_status", 32'(rd), 32'h00);

    for (int i = 0; i < 10; i++) begin
      if (tbl[i].wr) bw(tbl[i].off, tbl[i].d);
      br(tbl[i].off, rd);
      chk($sformatf("tbl%0d", i), 32'(rd), 32'(tbl[i].exp));
    end
    chk("tbl_colours", 32'(CONFIG_COLOURS), 32'h1CE0);
    fg_m = 8'h1C; bg_m = 8'hE0;

    // Basic pixel write and one-cycle VGA latency.
    pix(5, 3, 1'b1);
    vr(17'h00605, v); chk("pix_5_3", 32'(v), 32'h1);

    // Out-of-range X and Y are dropped.
    vr(17'h00140, p);
    pix(320, 0, ~p);
    vr(17'h00140, v); chk("drop_x320", 32'(v), 32'(p));
    vr(17'(pa(5, 240)), p);
    pix(5, 240, ~p);
    vr(17'(pa(5, 240)), v); chk("drop_y240", 32'(v), 32'(p));

    // Last in-range corner is accepted.
    pix(319, 239, 1'b1);
    vr(17'(pa(319, 239)), v); chk("corner_1", 32'(v), 32'h1);
    pix(319, 239, 1'b0);
    vr(17'(pa(319, 239)), v); chk("corner_0", 32'(v), 32'h0);

    // Same-cycle write and read returns old data, then VGA_DATA holds.
    pix(8, 2, 1'b0);
    pix(7, 2, 1'b0);
    VGA_ADDR = 17'(pa(7, 2)); VGA_RD_EN = 1'b1;
    BUS_ADDR = BASE + 8'd3; drv = 8'h01; drv_en = 1'b1; BUS_WE = 1'b1;
    @(posedge CLK); #1;
    BUS_WE = 1'b0; drv_en = 1'b0; BUS_ADDR = 8'h00; VGA_RD_EN = 1'b0;
    chk("read_first", 32'(VGA_DATA), 32'h0);
    mem_m[pa(7, 2)] = 1'b1;
    vr(17'(pa(7, 2)), v); chk("after_rf", 32'(v), 32'h1);
    VGA_ADDR = 17'(pa(8, 2));
    repeat (3) @(posedge CLK); #1;
    chk("vga_hold", 32'(VGA_DATA), 32'h1);

`ifdef FB_FILL_EN
    // Abort a fill with reset; mid-fill pixel and restart writes are ignored.
    vr(17'd5000, p2);
    bw(3'd6, 8'h03);
    br(3'd6, rd); chk("fill_busy", 32'(rd), 32'h01);
    repeat (8) @(posedge CLK); #1;
    bw(3'd0, 8'h00); bw(3'd1, 8'h00); bw(3'd2, 8'h00); bw(3'd3, 8'h00);
    bw(3'd6, 8'h01);
    repeat (975) @(posedge CLK); #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    br(3'd6, rd); chk("abort_busy", 32'(rd), 32'h00);
    chk("abort_colours", 32'(CONFIG_COLOURS), 32'hFF00);
    fg_m = 8'hFF; bg_m = 8'h00;
    vr(17'd10, v);   chk("abort_a10", 32'(v), 32'h1);
    vr(17'd0, v);    chk("abort_a0", 32'(v), 32'h1);
    vr(17'd5000, v); chk("abort_a5000", 32'(v), 32'(p2));
    vr(17'(pa(5, 3)), v); chk("abort_keep", 32'(v), 32'h1);
    for (int i = 0; i <= 900; i++) begin mem_m[i] = 1'b1; known_m[i] = 1'b1; end

    // Full fill: busy for exactly 131072 cycles, then everything reads the fill value.
    bw(3'd6, 8'h03);
    BUS_ADDR = BASE + 8'd6;
    busy_cnt = 0;
    for (int i = 0; i < 140000; i++) begin
      @(posedge CLK); #1;
      if (BUS_DATA[0] !== 1'b1) break;
      busy_cnt++;
    end
    BUS_ADDR = 8'h00;
    @(posedge CLK); #1;
    chk("fill_cycles", 32'(busy_cnt), 32'd131072);
    br(3'd6, rd); chk("fill_done", 32'(rd), 32'h00);
    for (int i = 0; i < 131072; i++) begin mem_m[i] = 1'b1; known_m[i] = 1'b1; end
    for (int i = 0; i < 16; i++) begin
      int a;
      a = int'($urandom_range(0, 131071));
      vr(17'(a), v); chk("fill_rand", 32'(v), 32'h1);
    end
`else
    // Without the fill engine, control writes do nothing and status reads 0.
    bw(3'd6, 8'h01);
    repeat (5) @(posedge CLK); #1;
    vr(17'(pa(5, 3)), v); chk("nofill_ram", 32'(v), 32'h1);
    br(3'd6, rd); chk("nofill_status", 32'(rd), 32'h00);
    bw(3'd6, 8'h03);
    pix(9, 9, 1'b1);
    vr(17'(pa(9, 9)), v); chk("nofill_pix", 32'(v), 32'h1);
`endif

    // Random pixels and colours against the reference picture.
    for (int i = 0; i < 150; i++) begin
      int  x, y, a;
      bit  bv;
      x  = int'($urandom_range(0, 399));
      y  = int'($urandom_range(0, 255));
      bv = 1'($urandom);
      a  = pa(x, y);
      pix(x, y, bv);
      br(3'd0, rd); chk("rnd_xlo", 32'(rd), 32'(x % 256));
      if (known_m[a]) begin
        vr(17'(a), v); chk("rnd_pix", 32'(v), 32'(mem_m[a]));
      end
      if (i % 10 == 0) begin
        fg_m = 8'($urandom);
        bg_m = 8'($urandom);
        bw(3'd4, fg_m);
        bw(3'd5, bg_m);
        chk("rnd_colours", 32'(CONFIG_COLOURS), {16'h0, fg_m, bg_m});
        br(3'd4, rd); chk("rnd_fg_rd", 32'(rd), 32'(fg_m));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
